// File: rtl/des.sv
// Cycle-counted inertial-delay models of a 2-input AND (out1) and a bufif0 (out2).
// A change is committed only after the same new target is sampled on D consecutive edges.
module des #(
    parameter int AND_RISE = 2,
    parameter int AND_FALL = 3,
    parameter int BUF_RISE = 5,
    parameter int BUF_FALL = 6,
    parameter int BUF_OFF  = 7,
    parameter int CNT_W    = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a,
    input  logic b,
    output logic out1,
    output logic out2,
    output logic out2_oe
);

    // out2 state is {oe, val}; the off state always stores val=0 so z has one encoding
    typedef enum logic [1:0] {
        DRV_Z  = 2'b00,
        DRV_LO = 2'b10,
        DRV_HI = 2'b11
    } drv_t;

    localparam logic [CNT_W-1:0] D_AND_RISE = CNT_W'(AND_RISE);
    localparam logic [CNT_W-1:0] D_AND_FALL = CNT_W'(AND_FALL);
    localparam logic [CNT_W-1:0] D_BUF_RISE = CNT_W'(BUF_RISE);
    localparam logic [CNT_W-1:0] D_BUF_FALL = CNT_W'(BUF_FALL);
    localparam logic [CNT_W-1:0] D_BUF_OFF  = CNT_W'(BUF_OFF);
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

    logic             s1;
    logic             p1;
    logic [CNT_W-1:0] c1;
    drv_t             s2;
    drv_t             p2;
    logic [CNT_W-1:0] c2;

    logic             t1;
    drv_t             t2;
    logic [CNT_W-1:0] d1;
    logic [CNT_W-1:0] d2;
    logic [CNT_W-1:0] n1;
    logic [CNT_W-1:0] n2;

    // Targets, delays for the transition toward them, and the count this edge would reach
    always_comb begin
        t1 = a & b;
        t2 = DRV_Z;
        if (!b) begin
            t2 = a ? DRV_HI : DRV_LO;
        end

        d1 = t1 ? D_AND_RISE : D_AND_FALL;

        d2 = D_BUF_OFF;
        case (t2)
            DRV_HI:  d2 = D_BUF_RISE;
            DRV_LO:  d2 = D_BUF_FALL;
            default: d2 = D_BUF_OFF;
        endcase

        n1 = ((t1 != p1) || (c1 == '0)) ? ONE : c1 + ONE;
        n2 = ((t2 != p2) || (c2 == '0)) ? ONE : c2 + ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            p1 <= 1'b0;
            c1 <= '0;
            s2 <= DRV_Z;
            p2 <= DRV_Z;
            c2 <= '0;
        end else begin
            if (t1 == s1) begin
                c1 <= '0;
            end else begin
                p1 <= t1;
                if (n1 == d1) begin
                    s1 <= t1;
                    c1 <= '0;
                end else begin
                    c1 <= n1;
                end
            end

            if (t2 == s2) begin
                c2 <= '0;
            end else begin
                p2 <= t2;
                if (n2 == d2) begin
                    s2 <= t2;
                    c2 <= '0;
                end else begin
                    c2 <= n2;
                end
            end
        end
    end

    assign out1    = s1;
    assign out2_oe = s2[1];
    assign out2    = s2[1] ? s2[0] : 1'bz;

endmodule

// File: tb/tb_des.sv
// Bench for des: a sample-history reference model checked every cycle, plus
// hand-computed edge-by-edge expectations for the directed scenarios.
module tb_des;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic a = 1'b0;
    logic b = 1'b0;
    wire  out1;
    wire  out2;
    wire  out2_oe;

    int tests = 0;
    int fails = 0;
    bit started = 1'b0;

    des dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (a),
        .b       (b),
        .out1    (out1),
        .out2    (out2),
        .out2_oe (out2_oe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: output value 0/1, or 2 for z. An output moves to the
    // sampled target once the trailing run of identical samples reaches the
    // delay for that transition.
    int m1 = 0;
    int m2 = 2;
    int h1[$];
    int h2[$];

    function automatic int trail(input int q[$]);
        int n = 0;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i] != q[q.size() - 1]) break;
            n++;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int t1, t2, dl1, dl2;
        if (!rst_n) begin
            m1 = 0;
            m2 = 2;
            h1.delete();
            h2.delete();
        end else begin
            t1 = (a && b) ? 1 : 0;
            t2 = b ? 2 : (a ? 1 : 0);
            h1.push_back(t1);
            h2.push_back(t2);
            dl1 = (t1 == 1) ? 2 : 3;
            dl2 = (t2 == 1) ? 5 : ((t2 == 0) ? 6 : 7);
            if (t1 != m1 && trail(h1) >= dl1) m1 = t1;
            if (t2 != m2 && trail(h2) >= dl2) m2 = t2;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("model_out1", int'(out1), m1);
            chk("model_oe", int'(out2_oe), (m2 != 2) ? 1 : 0);
            if (m2 != 2 && out2_oe) chk("model_out2", int'(out2), m2);
        end
    end

    task automatic set_in(input logic va, input logic vb);
        @(negedge clk);
        a = va;
        b = vb;
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        started = 1'b1;
        #1;
        chk("reset_out1", int'(out1), 0);
        chk("reset_oe", int'(out2_oe), 0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_hold_oe", int'(out2_oe), 0);

        // Release with a=0,b=0: z->0 takes 6 edges
        @(negedge clk);
        rst_n = 1'b1;
        edges(5);
        chk("idle_oe_e5", int'(out2_oe), 0);
        edges(1);
        chk("idle_oe_e6", int'(out2_oe), 1);
        chk("idle_out2_e6", int'(out2), 0);
        chk("idle_out1", int'(out1), 0);

        // a=1: out2 0->1 on 5th edge
        set_in(1'b1, 1'b0);
        edges(4);
        chk("rise2_e4", int'(out2), 0);
        edges(1);
        chk("rise2_e5", int'(out2), 1);
        chk("rise2_out1", int'(out1), 0);

        // b=1: out1 rises on 2nd edge, out2 off on 7th
        set_in(1'b1, 1'b1);
        edges(1);
        chk("rise1_e1", int'(out1), 0);
        edges(1);
        chk("rise1_e2", int'(out1), 1);
        edges(4);
        chk("off_e6", int'(out2_oe), 1);
        edges(1);
        chk("off_e7", int'(out2_oe), 0);

        // a=0: out1 falls on 3rd edge, out2 stays z
        set_in(1'b0, 1'b1);
        edges(2);
        chk("fall1_e2", int'(out1), 1);
        edges(1);
        chk("fall1_e3", int'(out1), 0);
        edges(5);
        chk("fall1_z", int'(out2_oe), 0);

        // b=0: z->0 on 6th edge
        set_in(1'b0, 1'b0);
        edges(5);
        chk("z2lo_e5", int'(out2_oe), 0);
        edges(1);
        chk("z2lo_e6_oe", int'(out2_oe), 1);
        chk("z2lo_e6_val", int'(out2), 0);

        // Glitch: a=1 for 4 edges never reaches out2
        set_in(1'b1, 1'b0);
        edges(4);
        set_in(1'b0, 1'b0);
        edges(10);
        chk("glitch2_oe", int'(out2_oe), 1);
        chk("glitch2_val", int'(out2), 0);

        // Glitch: a=b=1 for 1 edge never reaches out1 (and out2 off is cancelled)
        set_in(1'b1, 1'b1);
        edges(1);
        set_in(1'b0, 1'b0);
        edges(5);
        chk("glitch1_out1", int'(out1), 0);
        chk("glitch1_oe", int'(out2_oe), 1);

        // Target switch: 3 edges toward z, then toward 1 restarts from count 1
        set_in(1'b0, 1'b1);
        edges(3);
        chk("switch_no_z", int'(out2_oe), 1);
        set_in(1'b1, 1'b0);
        edges(4);
        chk("switch_e4_oe", int'(out2_oe), 1);
        chk("switch_e4_val", int'(out2), 0);
        edges(1);
        chk("switch_e5_val", int'(out2), 1);

        // Async reset while out1=1 and a fall is pending
        set_in(1'b1, 1'b1);
        edges(10);
        chk("pre_rst_out1", int'(out1), 1);
        set_in(1'b0, 1'b1);
        edges(1);
        #3 rst_n = 1'b0;
        #1;
        chk("async_out1", int'(out1), 0);
        chk("async_oe", int'(out2_oe), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        a = 1'b1;
        b = 1'b1;
        edges(1);
        chk("post_rst_e1", int'(out1), 0);
        edges(1);
        chk("post_rst_e2", int'(out1), 1);
        chk("post_rst_oe", int'(out2_oe), 0);

        edges(3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
